keypad_loader: RTL and testbench
================================

KEYPAD_LOADER -- requirements
Module: keypad_loader

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, the number of consecutive identical samples required to accept a key press or a release (legal range 1..15).
REQ-002 Port: clk  in  1  system clock; all state changes on the rising edge.
REQ-003 Port: clr  in  1  reset, asynchronous, active-high.
REQ-004 Port: keys  in  10  raw keypad lines; bit n high means digit key n is pressed.
REQ-005 Port: load_en  in  1  entry permitted (timer stopped); when low, all keys are ignored.
REQ-006 Port: clear_key  in  1  synchronous request to discard the current entry.
REQ-007 Port: data  out  4  BCD digit presented to the timer load interface.
REQ-008 Port: loadn  out  1  active-low load strobe, one cycle wide, qualifying data.
REQ-009 Port: digit_count  out  2  number of digits loaded in the current entry (0..3).
REQ-010 Port: key_err  out  1  high while keys holds a nonzero value that is not one-hot.

Function
REQ-011 The FSM SHALL have four states: IDLE, DEBOUNCE, LOAD, WAIT_RELEASE.
REQ-012 IDLE -> DEBOUNCE when load_en=1, keys is one-hot, and digit_count<3; the key value is captured.
REQ-013 In DEBOUNCE, each cycle keys equals the captured value increments the stable counter; any other value returns the FSM to IDLE and clears the counter.
REQ-014 DEBOUNCE -> LOAD after DEBOUNCE_CYCLES consecutive matching samples.
REQ-015 In LOAD (exactly one cycle), loadn=0 and data=BCD of the captured key; digit_count increments; next state is WAIT_RELEASE.
REQ-016 Latency: loadn falls on the edge following the DEBOUNCE_CYCLES-th consecutive matching sample; with the default of 4, this is the 5th edge after the key first appears.
REQ-017 WAIT_RELEASE -> IDLE after DEBOUNCE_CYCLES consecutive samples of keys=0; a repress during the count restarts the count; no second strobe is issued without a full release.
REQ-018 Outside LOAD, loadn SHALL be 1 and data SHALL hold the last loaded digit.
REQ-019 digit_count saturates at 3; when it is 3, presses are ignored (no strobe) until clear_key is asserted.
REQ-020 A multi-key or non-one-hot value SHALL never produce a strobe; key_err is combinationally high while it persists.
REQ-021 load_en=0 in DEBOUNCE or IDLE forces IDLE; load_en=0 in LOAD does not cancel the strobe already being issued.
REQ-022 clear_key=1 forces digit_count=0 and the state WAIT_RELEASE on the next edge; clear_key in the same cycle as LOAD cancels that strobe (clear wins, loadn stays 1).

Reset
REQ-023 While clr=1: state=IDLE, counters=0, data=4'd0, loadn=1, digit_count=0, key_err driven from keys only.
REQ-024 clr asserted mid-debounce or mid-LOAD SHALL abort immediately with no strobe; after release, the block starts from IDLE.

Configuration
REQ-025 Macro KEYPAD_ZERO_SKIP_EN: when defined, key 0 pressed while digit_count=0 is debounced but produces no strobe and no count change (leading zero suppressed); when undefined, it is loaded and counted like any other digit.

Structure
REQ-026 A shared package SHALL hold the FSM state enumeration, BCD_W=4, KEYS_W=10, and MAX_DIGITS=3.
REQ-027 The one-hot-to-BCD encoder and one-hot validity check SHALL be a sub-module, key_encoder (combinational: keys -> bcd, valid, err).

Verification
REQ-028 Press key 9 held for 10 cycles, default parameter -> one loadn low pulse on the 5th edge, data=9, digit_count=1.
REQ-029 Sequence 3, 0, 2, each with full release -> three strobes with data 3, 0, 2; digit_count=3; a 4th key 5 -> no strobe.
REQ-030 Key 7 bouncing 1,0,1,1,1,1 -> exactly one strobe, issued after 4 stable samples; keys=10'b0000010010 -> key_err=1, no strobe.
REQ-031 clear_key in the LOAD cycle of key 4 -> no strobe, digit_count=0; key 0 first with the macro defined -> no strobe; without the macro -> strobe with data=0.
REQ-032 clr pulse during DEBOUNCE of key 6 -> loadn stays 1, data=0, digit_count=0; load_en=0 while key 1 is pressed -> no strobe.

Source files
------------

// File: rtl/keypad_loader_pkg.sv
// keypad_loader_pkg
// Shared definitions for the keypad loader: FSM state encoding, bus widths,
// the maximum number of digits per entry and a bit-count helper used by the
// one-hot validity check.
package keypad_loader_pkg;

  localparam int BCD_W      = 4;
  localparam int KEYS_W     = 10;
  localparam int MAX_DIGITS = 3;
  // Width of the debounce / release counter (DEBOUNCE_CYCLES is 1..15)
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    LOAD         = 2'd2,
    WAIT_RELEASE = 2'd3
  } kl_state_e;

  // Number of set bits in a keypad sample
  function automatic logic [3:0] count_ones(input logic [KEYS_W-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < KEYS_W; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_loader_encoder.sv
// key_encoder
// Combinational one-hot keypad decoder.
// Ports:
//   keys  - raw keypad lines, bit n = digit key n pressed
//   bcd   - index of the pressed key (meaningful only when valid=1)
//   valid - exactly one key pressed
//   err   - more than one key pressed (nonzero but not one-hot)
module key_encoder
  import keypad_loader_pkg::*;
(
  input  logic [KEYS_W-1:0] keys,
  output logic [BCD_W-1:0]  bcd,
  output logic              valid,
  output logic              err
);

  logic [3:0] ones_s;

  // Priority encode the highest set bit and classify the sample
  always_comb begin
    bcd = {BCD_W{1'b0}};
    for (int i = 0; i < KEYS_W; i++) begin
      bcd = keys[i] ? BCD_W'(i) : bcd;
    end
    ones_s = count_ones(keys);
    valid  = (ones_s == 4'd1);
    err    = (ones_s > 4'd1);
  end

endmodule

// File: rtl/keypad_loader.sv
// keypad_loader
// Debounces a 10-key digit keypad and presents each accepted digit to a
// timer load interface as BCD with a one-cycle active-low strobe.
// Up to three digits are accepted per entry; clear_key starts a new entry.
// Ports:
//   clk         - system clock, rising edge
//   clr         - asynchronous active-high reset
//   keys        - raw keypad lines (bit n = digit n)
//   load_en     - entry permitted; when low, keys are ignored
//   clear_key   - synchronous request to discard the current entry
//   data        - BCD digit for the timer (holds last loaded digit)
//   loadn       - active-low load strobe, one cycle wide
//   digit_count - digits loaded in the current entry (0..3)
//   key_err     - high while keys is nonzero and not one-hot
// Build option:
//   KEYPAD_ZERO_SKIP_EN - when defined, a leading key 0 (digit_count=0) is
//                         debounced but neither strobed nor counted.
module keypad_loader
  import keypad_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
)
(
  input  logic              clk,
  input  logic              clr,
  input  logic [KEYS_W-1:0] keys,
  input  logic              load_en,
  input  logic              clear_key,
  output logic [BCD_W-1:0]  data,
  output logic              loadn,
  output logic [1:0]        digit_count,
  output logic              key_err
);

  // The counter value on which the final required sample is seen
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       MAX_COUNT = 2'(MAX_DIGITS);

  kl_state_e         state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [KEYS_W-1:0] cap_key_r, cap_key_s;
  logic [BCD_W-1:0]  cap_bcd_r, cap_bcd_s;
  logic [BCD_W-1:0]  data_r, data_s;
  logic [1:0]        count_r, count_s;
  logic [BCD_W-1:0]  key_bcd_s;
  logic              key_valid_s;
  logic              key_err_s;
  logic              skip_s;
  logic              strobe_s;

  key_encoder u_key_encoder (
    .keys  (keys),
    .bcd   (key_bcd_s),
    .valid (key_valid_s),
    .err   (key_err_s)
  );

`ifdef KEYPAD_ZERO_SKIP_EN
  // A debounced key 0 as the first digit is swallowed
  assign skip_s = (cap_bcd_r == 4'd0) && (count_r == 2'd0);
`else
  assign skip_s = 1'b0;
`endif

  // Next-state logic: clear_key overrides every state, including LOAD
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    cap_key_s = cap_key_r;
    cap_bcd_s = cap_bcd_r;
    data_s    = data_r;
    count_s   = count_r;
    if (clear_key) begin
      state_s = WAIT_RELEASE;
      cnt_s   = {CNT_W{1'b0}};
      count_s = 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_s = {CNT_W{1'b0}};
          if (load_en && key_valid_s && (count_r < MAX_COUNT)) begin
            state_s   = DEBOUNCE;
            cap_key_s = keys;
            cap_bcd_s = key_bcd_s;
          end else begin
            state_s = IDLE;
          end
        end
        DEBOUNCE: begin
          if (!load_en || (keys != cap_key_r)) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
          end else if (cnt_r == CNT_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = skip_s ? WAIT_RELEASE : LOAD;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        LOAD: begin
          // Strobe is committed here; load_en no longer matters
          data_s  = cap_bcd_r;
          count_s = count_r + 2'd1;
          cnt_s   = {CNT_W{1'b0}};
          state_s = WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (keys != {KEYS_W{1'b0}}) begin
            cnt_s = {CNT_W{1'b0}};
          end else if (cnt_r == CNT_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      cap_key_r <= {KEYS_W{1'b0}};
      cap_bcd_r <= {BCD_W{1'b0}};
      data_r    <= {BCD_W{1'b0}};
      count_r   <= 2'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      cap_key_r <= cap_key_s;
      cap_bcd_r <= cap_bcd_s;
      data_r    <= data_s;
      count_r   <= count_s;
    end
  end

  // A clear_key arriving in the LOAD cycle must suppress the strobe in that
  // same cycle, so the strobe is gated here rather than registered.
  always_comb begin
    strobe_s = (state_r == LOAD) && !clear_key;
    loadn    = !strobe_s;
    data     = strobe_s ? cap_bcd_r : data_r;
  end

  assign digit_count = count_r;
  assign key_err     = key_err_s;

endmodule

// File: tb/tb_keypad_loader.sv
// tb_keypad_loader
// Self-checking bench for keypad_loader (default DEBOUNCE_CYCLES=4).
// Stimulus is organised as press episodes: a key value held for some cycles
// followed by a release long enough to return the loader to idle.
module tb_keypad_loader;

  localparam int N   = 4;      // debounce cycles of the DUT default
  localparam int REL = N + 3;  // release cycles after every episode

  logic       clk = 1'b0;
  logic       clr;
  logic [9:0] keys;
  logic       load_en;
  logic       clear_key;
  logic [3:0] data;
  logic       loadn;
  logic [1:0] digit_count;
  logic       key_err;

  int n_tests = 0;
  int n_fail  = 0;
  int mcnt;
  int mdata;

  keypad_loader dut (
    .clk         (clk),
    .clr         (clr),
    .keys        (keys),
    .load_en     (load_en),
    .clear_key   (clear_key),
    .data        (data),
    .loadn       (loadn),
    .digit_count (digit_count),
    .key_err     (key_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] k;
    logic       en;
    logic       clr_k;
    int         hold;
    int         exp_strobe;
    int         exp_data;
    int         exp_cnt;
    int         exp_err;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: after the edge, apply the inputs for the next edge, then settle
  task automatic cycle(input logic [9:0] k, input logic en, input logic ck);
    @(posedge clk);
    #1;
    keys = k; load_en = en; clear_key = ck;
    #1;
  endtask

  // Hold k for 'hold' cycles then release; report strobe activity
  task automatic episode(input logic [9:0] k, input logic en, input int hold,
                         input int clear_at, output int nstrobe,
                         output int first_it, output int sdata,
                         output int err_seen);
    nstrobe = 0; first_it = -1; sdata = -1; err_seen = 0;
    for (int it = 0; it < hold + REL; it++) begin
      cycle((it < hold) ? k : 10'd0, en, (it == clear_at));
      if (it == 0) err_seen = int'(key_err);
      if (!loadn) begin
        nstrobe++;
        if (first_it < 0) begin
          first_it = it;
          sdata    = int'(data);
        end
      end
    end
  endtask

  // Reference rule: does this episode produce a strobe?
  function automatic int model_strobe(input logic [9:0] k, input logic en,
                                      input int hold, input int cnt);
    if (!en || $countones(k) != 1 || cnt >= 3 || hold < N + 1) return 0;
`ifdef KEYPAD_ZERO_SKIP_EN
    if (k == 10'd1 && cnt == 0) return 0;
`endif
    return 1;
  endfunction

  function automatic int key_index(input logic [9:0] k);
    int idx = 0;
    for (int i = 0; i < 10; i++) if (k[i]) idx = i;
    return idx;
  endfunction

  vec_t vecs[13];

  initial begin
    int ns, fi, sd, es, es_exp;
    logic [9:0] k;
    logic       en;
    int         hold, typ, a, b;

    // Table of episodes, applied in order from reset
    vecs[0]  = '{10'd1 << 9,   1'b1, 1'b0, 10, 1, 9, 1, 0};
    vecs[1]  = '{10'd0,        1'b1, 1'b1, 1,  0, 9, 0, 0};
    vecs[2]  = '{10'd1 << 3,   1'b1, 1'b0, 6,  1, 3, 1, 0};
    vecs[3]  = '{10'd1 << 0,   1'b1, 1'b0, 6,  1, 0, 2, 0};
    vecs[4]  = '{10'd1 << 2,   1'b1, 1'b0, 6,  1, 2, 3, 0};
    vecs[5]  = '{10'd1 << 5,   1'b1, 1'b0, 6,  0, 2, 3, 0};
    vecs[6]  = '{10'b0000010010, 1'b1, 1'b0, 6, 0, 2, 3, 1};
    vecs[7]  = '{10'd0,        1'b1, 1'b1, 1,  0, 2, 0, 0};
    vecs[8]  = '{10'd1 << 1,   1'b0, 1'b0, 6,  0, 2, 0, 0};
    vecs[9]  = '{10'd1 << 8,   1'b1, 1'b0, 4,  0, 2, 0, 0};
    vecs[10] = '{10'd1 << 8,   1'b1, 1'b0, 5,  1, 8, 1, 0};
    vecs[11] = '{10'd0,        1'b1, 1'b1, 1,  0, 8, 0, 0};
`ifdef KEYPAD_ZERO_SKIP_EN
    vecs[12] = '{10'd1 << 0,   1'b1, 1'b0, 6,  0, 8, 0, 0};
`else
    vecs[12] = '{10'd1 << 0,   1'b1, 1'b0, 6,  1, 0, 1, 0};
`endif

    // Reset state; key_err still follows keys while in reset
    clr = 1'b1; keys = 10'b0000010010; load_en = 1'b0; clear_key = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_loadn", int'(loadn), 1);
    check("rst_data", int'(data), 0);
    check("rst_count", int'(digit_count), 0);
    check("rst_key_err", int'(key_err), 1);
    keys = 10'd0;
    #1;
    check("rst_key_err_clear", int'(key_err), 0);
    @(posedge clk); #1; clr = 1'b0;

    for (int i = 0; i < 13; i++) begin
      episode(vecs[i].k, vecs[i].en, vecs[i].hold, vecs[i].clr_k ? 0 : -1,
              ns, fi, sd, es);
      check($sformatf("vec%0d_strobes", i), ns, vecs[i].exp_strobe);
      if (vecs[i].exp_strobe != 0) begin
        check($sformatf("vec%0d_strobe_cycle", i), fi, N + 1);
        check($sformatf("vec%0d_strobe_data", i), sd, vecs[i].exp_data);
      end
      check($sformatf("vec%0d_count", i), int'(digit_count), vecs[i].exp_cnt);
      check($sformatf("vec%0d_data_hold", i), int'(data), vecs[i].exp_data);
      check($sformatf("vec%0d_key_err", i), es, vecs[i].exp_err);
    end
    mdata = vecs[12].exp_data;

    // New entry, then key 7 bouncing 1,0,1,1,1,1,... : one strobe after the
    // bounce settles (capture on edge 3, four matches, strobe after edge 7)
    episode(10'd0, 1'b1, 1, 0, ns, fi, sd, es);
    mcnt = 0;
    ns = 0; fi = -1; sd = -1;
    for (int it = 0; it < 8 + REL; it++) begin
      cycle((it < 8 && it != 1) ? (10'd1 << 7) : 10'd0, 1'b1, 1'b0);
      if (!loadn) begin
        ns++;
        if (fi < 0) begin fi = it; sd = int'(data); end
      end
    end
    check("bounce_strobes", ns, 1);
    check("bounce_strobe_cycle", fi, 7);
    check("bounce_data", sd, 7);
    check("bounce_count", int'(digit_count), 1);
    mcnt = 1; mdata = 7;

    // clear_key in the LOAD cycle of key 4 cancels the strobe
    episode(10'd1 << 4, 1'b1, 8, N + 1, ns, fi, sd, es);
    check("clear_in_load_strobes", ns, 0);
    check("clear_in_load_count", int'(digit_count), 0);
    check("clear_in_load_data", int'(data), mdata);
    mcnt = 0;

    episode(10'd1 << 3, 1'b1, 6, -1, ns, fi, sd, es);
    check("pre_clr_strobes", ns, 1);
    mcnt = 1; mdata = 3;

    // clr pulse during debounce of key 6
    ns = 0;
    for (int it = 0; it < 3 + REL; it++) begin
      cycle((it < 2) ? (10'd1 << 6) : 10'd0, 1'b1, 1'b0);
      clr = (it == 2);
      #1;
      if (it == 2) begin
        check("clr_loadn", int'(loadn), 1);
        check("clr_data", int'(data), 0);
        check("clr_count", int'(digit_count), 0);
      end
      if (!loadn) ns++;
    end
    check("clr_no_strobe", ns, 0);
    mcnt = 0; mdata = 0;

    // Randomised episodes against the reference rules
    for (int e = 0; e < 40; e++) begin
      typ = $urandom_range(0, 19);
      if (typ < 2) begin
        episode(10'd0, 1'b1, 1, 0, ns, fi, sd, es);
        mcnt = 0;
        check("rnd_clear_strobes", ns, 0);
        check("rnd_clear_count", int'(digit_count), 0);
        continue;
      end
      if (typ < 5) begin
        a = $urandom_range(0, 9);
        b = (a + $urandom_range(1, 9)) % 10;
        k = (10'd1 << a) | (10'd1 << b);
      end else begin
        k = 10'd1 << $urandom_range(0, 9);
      end
      en   = ($urandom_range(0, 9) != 0);
      hold = $urandom_range(1, 9);
      es_exp = ($countones(k) > 1) ? 1 : 0;
      episode(k, en, hold, -1, ns, fi, sd, es);
      if (model_strobe(k, en, hold, mcnt) != 0) begin
        mcnt++;
        mdata = key_index(k);
        check("rnd_strobes", ns, 1);
        check("rnd_strobe_cycle", fi, N + 1);
        check("rnd_strobe_data", sd, mdata);
      end else begin
        check("rnd_strobes", ns, 0);
      end
      check("rnd_count", int'(digit_count), mcnt);
      check("rnd_data_hold", int'(data), mdata);
      check("rnd_key_err", es, es_exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
